mem_port_arbiter: RTL and testbench

Arbitrates one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage pipelined MIPS CPU. It sequences each access through a request/acknowledge state machine and registers the memory-side signals. It raises per-stage stall outputs that the pipeline controller ORs into its stage enable logic. A watchdog aborts any memory transaction that does not complete in time.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the signals between the pipeline stages, the arbiter and the
// single-port unified memory.
//   fetch side : if_req, if_addr  -> arbiter;  if_rdata, if_ack  <- arbiter
//   data side  : d_ren, d_wen, d_addr, d_wdata -> arbiter;
//                d_rdata, d_ack, bus_err <- arbiter
//   stalls     : stall_if, stall_mem <- arbiter (combinational)
//   memory     : mem_cs, mem_we, mem_addr, mem_dout <- arbiter (registered);
//                mem_din, mem_ack -> arbiter
// Modports: slave = the arbiter, master = pipeline + memory environment.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;

    logic                  d_ren;
    logic                  d_wen;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ack;
    logic                  bus_err;

    logic                  stall_if;
    logic                  stall_mem;

    logic                  mem_cs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_ack;

    modport slave (
        input  if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, mem_din, mem_ack,
        output if_rdata, if_ack, d_rdata, d_ack, bus_err, stall_if, stall_mem,
               mem_cs, mem_we, mem_addr, mem_dout
    );

    modport master (
        output if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, mem_din, mem_ack,
        input  if_rdata, if_ack, d_rdata, d_ack, bus_err, stall_if, stall_mem,
               mem_cs, mem_we, mem_addr, mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// load/store (MEM). Each access runs IDLE -> BUSY -> RESP; data requests win
// over fetches. A watchdog aborts an access that sees no mem_ack within
// TIMEOUT BUSY cycles and reports it with bus_err alongside the ack.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active low
//   bus  - mem_port_arbiter_if.slave (requests, responses, stalls, memory bus)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access open; grants data first, then fetch
// BUSY  | mem_cs high, waiting for mem_ack or the watchdog
// RESP  | one cycle with the owner's ack (and bus_err on abort) high
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF   = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    // Counter runs 0..TIMEOUT-1 inside BUSY; reaching the last value without
    // an ack means TIMEOUT cycles have passed.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    grant_t     grant, grant_next;
    logic [7:0] wait_cnt;
    logic       d_req;
    logic       start;
    logic       done_ok;
    logic       done_abort;

    assign d_req = bus.d_ren | bus.d_wen;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= GNT_IF;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        start      = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                // Data belongs to the older instruction, so it goes first.
                if (d_req) begin
                    state_next = ST_BUSY;
                    grant_next = GNT_DATA;
                    start      = 1'b1;
                end else if (bus.if_req) begin
                    state_next = ST_BUSY;
                    grant_next = GNT_IF;
                    start      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    state_next = ST_RESP;
                    done_ok    = 1'b1;
                end else if (wait_cnt == LAST_CNT) begin
                    state_next = ST_RESP;
                    done_abort = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.mem_cs   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {ADDR_WIDTH{1'b0}};
            bus.mem_dout <= {DATA_WIDTH{1'b0}};
            bus.if_rdata <= {DATA_WIDTH{1'b0}};
            bus.d_rdata  <= {DATA_WIDTH{1'b0}};
            bus.if_ack   <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.bus_err  <= 1'b0;
            wait_cnt     <= 8'd0;
        end else begin
            // Acks and bus_err are only ever set on the BUSY->RESP edge, so
            // clearing them by default makes them single-cycle pulses.
            bus.if_ack  <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.bus_err <= 1'b0;

            if (state == ST_BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (start) begin
                bus.mem_cs   <= 1'b1;
                bus.mem_addr <= d_req ? bus.d_addr : bus.if_addr;
                // Read and write together is served as a write.
                bus.mem_we   <= d_req & bus.d_wen;
                bus.mem_dout <= bus.d_wdata;
                wait_cnt     <= 8'd0;
            end

            if (done_ok) begin
                bus.mem_cs <= 1'b0;
                bus.mem_we <= 1'b0;
                if (grant == GNT_DATA) begin
                    bus.d_rdata <= bus.mem_din;
                    bus.d_ack   <= 1'b1;
                end else begin
                    bus.if_rdata <= bus.mem_din;
                    bus.if_ack   <= 1'b1;
                end
            end

            if (done_abort) begin
                // A write enable without chip select is meaningless, so it
                // drops together with mem_cs.
                bus.mem_cs  <= 1'b0;
                bus.mem_we  <= 1'b0;
                bus.bus_err <= 1'b1;
                if (grant == GNT_DATA) begin
                    bus.d_rdata <= {DATA_WIDTH{1'b0}};
                    bus.d_ack   <= 1'b1;
                end else begin
                    bus.if_rdata <= {DATA_WIDTH{1'b0}};
                    bus.if_ack   <= 1'b1;
                end
            end
        end
    end

    // A requester stops stalling in the RESP cycle that carries its own ack.
    assign bus.stall_if  = bus.if_req & ~((state == ST_RESP) & (grant == GNT_IF));
    assign bus.stall_mem = d_req      & ~((state == ST_RESP) & (grant == GNT_DATA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed vector table, hand-written timeout and reset sequences, then
// random traffic compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 fetch, 2 data; waited counts BUSY cycles already spent
    int          m_owner  = 0;
    int          m_waited = 0;
    bit          m_resp   = 1'b0;
    logic        e_cs = 0, e_we = 0, e_iack = 0, e_dack = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_dout = 0, e_irdata = 0, e_drdata = 0;

    task automatic model_step();
        if (!rst) begin
            m_owner = 0; m_waited = 0; m_resp = 1'b0;
            e_cs = 0; e_we = 0; e_iack = 0; e_dack = 0; e_err = 0;
            e_addr = 0; e_dout = 0; e_irdata = 0; e_drdata = 0;
        end else begin
            e_iack = 0; e_dack = 0; e_err = 0;
            if (m_resp) begin
                m_resp  = 1'b0;
                m_owner = 0;
            end else if (m_owner != 0) begin
                m_waited = m_waited + 1;
                if (bus.mem_ack || m_waited == TO) begin
                    logic [31:0] rd;
                    rd     = bus.mem_ack ? bus.mem_din : 32'h0;
                    e_err  = !bus.mem_ack;
                    e_cs   = 0;
                    e_we   = 0;
                    m_resp = 1'b1;
                    if (m_owner == 1) begin e_iack = 1; e_irdata = rd; end
                    else              begin e_dack = 1; e_drdata = rd; end
                end
            end else if (bus.d_ren || bus.d_wen) begin
                m_owner = 2; m_waited = 0;
                e_cs = 1; e_we = bus.d_wen; e_addr = bus.d_addr; e_dout = bus.d_wdata;
            end else if (bus.if_req) begin
                m_owner = 1; m_waited = 0;
                e_cs = 1; e_we = 0; e_addr = bus.if_addr; e_dout = bus.d_wdata;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_cs"},     bus.mem_cs,   e_cs);
        chk({tag, "_we"},     bus.mem_we,   e_we);
        chk({tag, "_addr"},   bus.mem_addr, e_addr);
        chk({tag, "_dout"},   bus.mem_dout, e_dout);
        chk({tag, "_iack"},   bus.if_ack,   e_iack);
        chk({tag, "_irdata"}, bus.if_rdata, e_irdata);
        chk({tag, "_dack"},   bus.d_ack,    e_dack);
        chk({tag, "_drdata"}, bus.d_rdata,  e_drdata);
        chk({tag, "_err"},    bus.bus_err,  e_err);
    endtask

    // One clock cycle with the model checking stalls before the edge and the
    // registered outputs after it. Called at a negedge with inputs driven.
    task automatic step(input string tag);
        #1;
        chk({tag, "_sif"},  bus.stall_if,
            bus.if_req & !(m_resp && m_owner == 1));
        chk({tag, "_smem"}, bus.stall_mem,
            (bus.d_ren | bus.d_wen) & !(m_resp && m_owner == 2));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        d_ren, d_wen;
        logic [31:0] d_addr, d_wdata;
        logic        mem_ack;
        logic [31:0] mem_din;
        logic        s_if, s_mem, cs, we;
        logic [31:0] maddr, mdout;
        logic        iack;
        logic [31:0] irdata;
        logic        dack;
        logic [31:0] drdata;
        logic        err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic fill_table();
        //           rst  ifr  if_addr     ren  wen  d_addr      d_wdata       ack  mem_din         sif  smem cs   we   maddr       mdout         iack irdata        dack drdata        err
        vecs[0]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
        // fetch only
        vecs[1]  = '{1'b1,1'b1,32'h40,     1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,32'h40,     32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
        vecs[2]  = '{1'b1,1'b1,32'h40,     1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h2008_0005, 1'b1,1'b0,1'b0,1'b0,32'h40,     32'h0,        1'b1,32'h2008_0005,1'b0,32'h0,        1'b0};
        vecs[3]  = '{1'b1,1'b1,32'h44,     1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h40,     32'h0,        1'b0,32'h2008_0005,1'b0,32'h0,        1'b0};
        // simultaneous fetch and load: data first
        vecs[4]  = '{1'b1,1'b1,32'h44,     1'b1,1'b0,32'h100,    32'h0,        1'b0,32'h0,         1'b1,1'b1,1'b1,1'b0,32'h100,    32'h0,        1'b0,32'h2008_0005,1'b0,32'h0,        1'b0};
        vecs[5]  = '{1'b1,1'b1,32'h44,     1'b1,1'b0,32'h100,    32'h0,        1'b1,32'h1111_2222, 1'b1,1'b1,1'b0,1'b0,32'h100,    32'h0,        1'b0,32'h2008_0005,1'b1,32'h1111_2222,1'b0};
        vecs[6]  = '{1'b1,1'b1,32'h44,     1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,32'h100,    32'h0,        1'b0,32'h2008_0005,1'b0,32'h1111_2222,1'b0};
        vecs[7]  = '{1'b1,1'b1,32'h44,     1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,32'h44,     32'h0,        1'b0,32'h2008_0005,1'b0,32'h1111_2222,1'b0};
        vecs[8]  = '{1'b1,1'b1,32'h44,     1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h3C01_0001, 1'b1,1'b0,1'b0,1'b0,32'h44,     32'h0,        1'b1,32'h3C01_0001,1'b0,32'h1111_2222,1'b0};
        vecs[9]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h44,     32'h0,        1'b0,32'h3C01_0001,1'b0,32'h1111_2222,1'b0};
        // store with two wait cycles
        vecs[10] = '{1'b1,1'b0,32'h0,      1'b0,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h0,         1'b0,1'b1,1'b1,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h3C01_0001,1'b0,32'h1111_2222,1'b0};
        vecs[11] = '{1'b1,1'b0,32'h0,      1'b0,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h0,         1'b0,1'b1,1'b1,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h3C01_0001,1'b0,32'h1111_2222,1'b0};
        vecs[12] = '{1'b1,1'b0,32'h0,      1'b0,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h0,         1'b0,1'b1,1'b1,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h3C01_0001,1'b0,32'h1111_2222,1'b0};
        vecs[13] = '{1'b1,1'b0,32'h0,      1'b0,1'b1,32'h200,    32'hDEAD_BEEF,1'b1,32'hAAAA_5555, 1'b0,1'b1,1'b0,1'b0,32'h200,    32'hDEAD_BEEF,1'b0,32'h3C01_0001,1'b1,32'hAAAA_5555,1'b0};
        vecs[14] = '{1'b1,1'b0,32'h0,      1'b0,1'b1,32'h200,    32'hDEAD_BEEF,1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h200,    32'hDEAD_BEEF,1'b0,32'h3C01_0001,1'b0,32'hAAAA_5555,1'b0};
        // read and write together: one write access
        vecs[15] = '{1'b1,1'b0,32'h0,      1'b1,1'b1,32'h300,    32'h1234_5678,1'b0,32'h0,         1'b0,1'b1,1'b1,1'b1,32'h300,    32'h1234_5678,1'b0,32'h3C01_0001,1'b0,32'hAAAA_5555,1'b0};
        vecs[16] = '{1'b1,1'b0,32'h0,      1'b1,1'b1,32'h300,    32'h1234_5678,1'b1,32'h0BAD_F00D, 1'b0,1'b1,1'b0,1'b0,32'h300,    32'h1234_5678,1'b0,32'h3C01_0001,1'b1,32'h0BAD_F00D,1'b0};
        vecs[17] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h300,    32'h1234_5678,1'b0,32'h3C01_0001,1'b0,32'h0BAD_F00D,1'b0};
        vecs[18] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,32'h300,    32'h1234_5678,1'b0,32'h3C01_0001,1'b0,32'h0BAD_F00D,1'b0};
    endtask

    task automatic drive_idle();
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_ren = 0; bus.d_wen = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ack = 0; bus.mem_din = 0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        fill_table();
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            rst         = vecs[i].rst;
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].if_addr;
            bus.d_ren   = vecs[i].d_ren;
            bus.d_wen   = vecs[i].d_wen;
            bus.d_addr  = vecs[i].d_addr;
            bus.d_wdata = vecs[i].d_wdata;
            bus.mem_ack = vecs[i].mem_ack;
            bus.mem_din = vecs[i].mem_din;
            #1;
            chk({t, "_sif"},  bus.stall_if,  vecs[i].s_if);
            chk({t, "_smem"}, bus.stall_mem, vecs[i].s_mem);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk({t, "_cs"},     bus.mem_cs,   vecs[i].cs);
            chk({t, "_we"},     bus.mem_we,   vecs[i].we);
            chk({t, "_addr"},   bus.mem_addr, vecs[i].maddr);
            chk({t, "_dout"},   bus.mem_dout, vecs[i].mdout);
            chk({t, "_iack"},   bus.if_ack,   vecs[i].iack);
            chk({t, "_irdata"}, bus.if_rdata, vecs[i].irdata);
            chk({t, "_dack"},   bus.d_ack,    vecs[i].dack);
            chk({t, "_drdata"}, bus.d_rdata,  vecs[i].drdata);
            chk({t, "_err"},    bus.bus_err,  vecs[i].err);
        end

        // ---------------- timeout: load with mem_ack held low ----------------
        begin
            int busy_cycles;
            bit got_ack;
            drive_idle();
            bus.d_ren = 1; bus.d_addr = 32'h400; bus.mem_din = 32'hFFFF_FFFF;
            step("to_start");
            chk("to_cs_on", bus.mem_cs, 1);
            busy_cycles = bus.mem_cs ? 1 : 0;
            got_ack = 0;
            for (int i = 0; i < 10 && !got_ack; i++) begin
                step("to_wait");
                if (bus.d_ack) got_ack = 1;
                else if (bus.mem_cs) busy_cycles++;
            end
            chk("to_ack_seen", 32'(got_ack), 1);
            chk("to_busy_cycles", busy_cycles, TO);
            chk("to_err", bus.bus_err, 1);
            chk("to_rdata_zero", bus.d_rdata, 0);
            chk("to_cs_off", bus.mem_cs, 0);
            bus.d_ren = 0;
            step("to_resp");
            chk("to_ack_clear", bus.d_ack, 0);
            chk("to_err_clear", bus.bus_err, 0);
        end

        // ---------------- reset in the second BUSY cycle ----------------
        drive_idle();
        bus.if_req = 1; bus.if_addr = 32'h80;
        step("rs_grant");
        step("rs_busy1");
        chk("rs_cs_busy2", bus.mem_cs, 1);
        rst = 1'b0;
        step("rs_reset");
        chk("rs_cs_off", bus.mem_cs, 0);
        chk("rs_iack_off", bus.if_ack, 0);
        chk("rs_dack_off", bus.d_ack, 0);
        rst = 1'b1;
        step("rs_regrant");
        chk("rs_cs_again", bus.mem_cs, 1);
        chk("rs_addr_again", bus.mem_addr, 32'h80);
        bus.mem_ack = 1; bus.mem_din = 32'h0000_0C0C;
        step("rs_ack");
        chk("rs_iack", bus.if_ack, 1);
        chk("rs_irdata", bus.if_rdata, 32'h0000_0C0C);
        drive_idle();
        step("rs_resp");

        // ---------------- random traffic vs. reference model ----------------
        for (int c = 0; c < 3000; c++) begin
            if (bus.if_ack || (!bus.if_req && $urandom_range(0, 3) == 0)) begin
                bus.if_req  = $urandom_range(0, 1);
                bus.if_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
            end
            if (bus.d_ack || (!bus.d_ren && !bus.d_wen && $urandom_range(0, 3) == 0)) begin
                int op;
                op = $urandom_range(0, 3);
                bus.d_ren   = (op == 1) || (op == 3);
                bus.d_wen   = (op == 2) || (op == 3);
                bus.d_addr  = {$urandom_range(0, 32'h3FFF), 2'b00};
                bus.d_wdata = $urandom;
            end
            bus.mem_ack = ($urandom_range(0, 2) == 0);
            bus.mem_din = $urandom;
            rst = ($urandom_range(0, 199) != 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
